// File: rtl/hog_norm_pkg.sv
// Shared constants for the HOG block-normalisation phase controller:
// FSM encodings, port-A owner codes, error bit positions and cell count helpers.
package hog_norm_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SOS_RUN   = 3'd1;
    localparam logic [2:0] ST_SOS_DRAIN = 3'd2;
    localparam logic [2:0] ST_NORM_RUN  = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_SOS  = 2'd1;
    localparam logic [1:0] OWN_NORM = 2'd2;

    localparam int unsigned ERR_OVERRUN = 0;
    localparam int unsigned ERR_STRAY   = 1;

    localparam int unsigned CNT_W         = 11;
    localparam int unsigned DEF_CELL_ROWS = 32;
    localparam int unsigned DEF_CELL_COLS = 32;
    localparam int unsigned CELLS         = DEF_CELL_ROWS * DEF_CELL_COLS;

    // Owner of the histogram port A for a given controller state.
    function automatic logic [1:0] owner_of(input logic [2:0] st);
        case (st)
            ST_SOS_RUN, ST_SOS_DRAIN: owner_of = OWN_SOS;
            ST_NORM_RUN:              owner_of = OWN_NORM;
            default:                  owner_of = OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/hog_bank_addr_mux.sv
// Owner-selected port address mux for the four histogram BRAM banks.
// Purely combinational so reader-to-BRAM latency is untouched.
module hog_bank_addr_mux
    import hog_norm_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned NBANKS = 4
) (
    input  logic [1:0]               sel,
    input  logic [NBANKS*ADDR_W-1:0] sos_addr,
    input  logic [NBANKS*ADDR_W-1:0] norm_addr,
    output logic [NBANKS*ADDR_W-1:0] bank_addr
);

    always_comb begin
        case (sel)
            OWN_SOS:  bank_addr = sos_addr;
            OWN_NORM: bank_addr = norm_addr;
            default:  bank_addr = '0;
        endcase
    end

endmodule

// File: rtl/hog_norm_phase_ctrl.sv
// Phase controller for HOG block normalisation: sequences the sum-of-squares
// pass, a drain gap, then the normalisation pass, owning histogram port A.
module hog_norm_phase_ctrl
    import hog_norm_pkg::*;
#(
    parameter int unsigned CELL_ROWS    = 32,
    parameter int unsigned CELL_COLS    = 32,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned DELAY        = 1
) (
    input  logic                  aclk,
    input  logic                  arest_n,
    input  logic                  histogram_done,
    output logic                  sos_start,
    input  logic                  sos_valid,
    input  logic [4*ADDR_W-1:0]   sos_addra,
    output logic                  norm_start,
    input  logic                  norm_cell_valid,
    input  logic [4*ADDR_W-1:0]   norm_addra,
    output logic [4*ADDR_W-1:0]   normal_addra,
    output logic [1:0]            owner,
    output logic                  busy,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      cell_cnt,
    output logic [1:0]            err
);

    localparam int unsigned      NCELLS     = CELL_ROWS * CELL_COLS;
    localparam logic [CNT_W-1:0] LAST_CELL  = CNT_W'(NCELLS - 1);
    localparam int unsigned      DRN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

    // DELAY is retained for interface compatibility; registers update without delay.
    logic unused_delay;
    assign unused_delay = (DELAY != 0);

    logic [2:0]       state, state_nxt;
    logic [DRN_W-1:0] drain_cnt, drain_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       err_nxt;
    logic             sos_start_nxt, norm_start_nxt;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cell_cnt;
        drain_nxt      = drain_cnt;
        sos_start_nxt  = 1'b0;
        norm_start_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (histogram_done) begin
                    state_nxt     = ST_SOS_RUN;
                    cnt_nxt       = '0;
                    sos_start_nxt = 1'b1;
                end
            end
            ST_SOS_RUN: begin
                if (sos_valid) begin
                    if (cell_cnt == LAST_CELL) begin
                        state_nxt = ST_SOS_DRAIN;
                        cnt_nxt   = '0;
                        drain_nxt = DRAIN_LOAD;
                    end else begin
                        cnt_nxt = cell_cnt + 1'b1;
                    end
                end
            end
            ST_SOS_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt      = ST_NORM_RUN;
                    norm_start_nxt = 1'b1;
                end else begin
                    drain_nxt = drain_cnt - 1'b1;
                end
            end
            ST_NORM_RUN: begin
                if (norm_cell_valid) begin
                    cnt_nxt = cell_cnt + 1'b1;
                    if (cell_cnt == LAST_CELL) state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A valid pulse is stray whenever its own pass is not running.
    always_comb begin
        err_nxt = err;
        if (histogram_done && (state != ST_IDLE))
            err_nxt[ERR_OVERRUN] = 1'b1;
        if ((sos_valid && (state != ST_SOS_RUN)) ||
            (norm_cell_valid && (state != ST_NORM_RUN)))
            err_nxt[ERR_STRAY] = 1'b1;
    end

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            state      <= ST_IDLE;
            cell_cnt   <= '0;
            drain_cnt  <= '0;
            err        <= '0;
            owner      <= OWN_NONE;
            sos_start  <= 1'b0;
            norm_start <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cell_cnt   <= cnt_nxt;
            drain_cnt  <= drain_nxt;
            err        <= err_nxt;
            owner      <= owner_of(state_nxt);
            sos_start  <= sos_start_nxt;
            norm_start <= norm_start_nxt;
            frame_done <= (state_nxt == ST_DONE);
        end
    end

    assign busy = (state != ST_IDLE);

    hog_bank_addr_mux #(
        .ADDR_W (ADDR_W),
        .NBANKS (4)
    ) u_addr_mux (
        .sel       (owner),
        .sos_addr  (sos_addra),
        .norm_addr (norm_addra),
        .bank_addr (normal_addra)
    );

endmodule

// File: tb/tb_hog_norm_phase_ctrl.sv
// Randomised self-checking bench for hog_norm_phase_ctrl: drives full frames with
// random pulse gaps and addresses, checking against expectations from pass/cell arithmetic.
module tb_hog_norm_phase_ctrl;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned NCELLS = 1024;
    localparam int unsigned DRAIN  = 4;

    logic              aclk = 1'b0;
    logic              arest_n;
    logic              histogram_done;
    logic              sos_start;
    logic              sos_valid;
    logic [4*ADDR_W-1:0] sos_addra;
    logic              norm_start;
    logic              norm_cell_valid;
    logic [4*ADDR_W-1:0] norm_addra;
    logic [4*ADDR_W-1:0] normal_addra;
    logic [1:0]        owner;
    logic              busy;
    logic              frame_done;
    logic [10:0]       cell_cnt;
    logic [1:0]        err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [1:0]  exp_owner = 2'd0;
    logic [1:0]  exp_err   = 2'b00;

    always #5 aclk = ~aclk;

    hog_norm_phase_ctrl #(
        .CELL_ROWS    (32),
        .CELL_COLS    (32),
        .DRAIN_CYCLES (DRAIN),
        .ADDR_W       (ADDR_W),
        .DELAY        (1)
    ) dut (
        .aclk            (aclk),
        .arest_n         (arest_n),
        .histogram_done  (histogram_done),
        .sos_start       (sos_start),
        .sos_valid       (sos_valid),
        .sos_addra       (sos_addra),
        .norm_start      (norm_start),
        .norm_cell_valid (norm_cell_valid),
        .norm_addra      (norm_addra),
        .normal_addra    (normal_addra),
        .owner           (owner),
        .busy            (busy),
        .frame_done      (frame_done),
        .cell_cnt        (cell_cnt),
        .err             (err)
    );

    // One clock of stimulus with fresh random addresses; checks the mux before
    // the edge and the sticky error flags after it. Called at edge+1.
    task automatic drive_cycle(input logic hd, input logic sv, input logic nv);
        logic [63:0] r;
        logic [4*ADDR_W-1:0] exp_addr;
        r = {$urandom(), $urandom()};
        sos_addra = r[4*ADDR_W-1:0];
        r = {$urandom(), $urandom()};
        norm_addra = r[4*ADDR_W-1:0];
        histogram_done  = hd;
        sos_valid       = sv;
        norm_cell_valid = nv;
        #1;
        exp_addr = (exp_owner == 2'd1) ? sos_addra :
                   (exp_owner == 2'd2) ? norm_addra : '0;
        n_checks++;
        if (normal_addra !== exp_addr) begin
            n_fail++;
            $display("FAIL addr_mux: got %h expected %h (owner exp %0d)", normal_addra, exp_addr, exp_owner);
        end
        @(posedge aclk);
        #1;
        histogram_done  = 1'b0;
        sos_valid       = 1'b0;
        norm_cell_valid = 1'b0;
        n_checks++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL err_flags: got %b expected %b", err, exp_err);
        end
    endtask

    // Full frame: start, NCELLS sos pulses, drain gap, NCELLS norm pulses, done.
    task automatic run_frame(input bit overrun, input bit strays);
        int unsigned gap;
        logic stray_nv, stray_sv, hd;
        exp_owner = 2'd0;
        drive_cycle(1'b1, 1'b0, 1'b0);
        exp_owner = 2'd1;
        n_checks++;
        if ({sos_start, norm_start, owner, busy, frame_done, cell_cnt} !== {1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 11'd0}) begin
            n_fail++;
            $display("FAIL frame_start: got sos_start=%b norm_start=%b owner=%0d busy=%b fd=%b cnt=%0d expected 1 0 1 1 0 0",
                     sos_start, norm_start, owner, busy, frame_done, cell_cnt);
        end
        for (int k = 0; k < int'(NCELLS); k++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < int'(gap); g++) begin
                drive_cycle(1'b0, 1'b0, 1'b0);
                n_checks++;
                if ({owner, sos_start, cell_cnt} !== {2'd1, 1'b0, 11'(k)}) begin
                    n_fail++;
                    $display("FAIL sos_idle: got owner=%0d sos_start=%b cnt=%0d expected 1 0 %0d", owner, sos_start, cell_cnt, k);
                end
            end
            stray_nv = strays && (k == 300);
            if (stray_nv) exp_err[1] = 1'b1;
            drive_cycle(1'b0, 1'b1, stray_nv);
            n_checks++;
            if ({owner, busy, sos_start, cell_cnt} !== {2'd1, 1'b1, 1'b0, (k == int'(NCELLS) - 1) ? 11'd0 : 11'(k + 1)}) begin
                n_fail++;
                $display("FAIL sos_count: got owner=%0d busy=%b sos_start=%b cnt=%0d after pulse %0d", owner, busy, sos_start, cell_cnt, k);
            end
        end
        for (int d = 0; d < int'(DRAIN) - 1; d++) begin
            stray_sv = strays && (d == 0);
            if (stray_sv) exp_err[1] = 1'b1;
            drive_cycle(1'b0, stray_sv, 1'b0);
            n_checks++;
            if ({owner, norm_start, cell_cnt} !== {2'd1, 1'b0, 11'd0}) begin
                n_fail++;
                $display("FAIL drain: got owner=%0d norm_start=%b cnt=%0d expected 1 0 0 (drain step %0d)", owner, norm_start, cell_cnt, d);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0);
        exp_owner = 2'd2;
        n_checks++;
        if ({norm_start, owner, busy, cell_cnt} !== {1'b1, 2'd2, 1'b1, 11'd0}) begin
            n_fail++;
            $display("FAIL norm_start: got norm_start=%b owner=%0d busy=%b cnt=%0d expected 1 2 1 0", norm_start, owner, busy, cell_cnt);
        end
        for (int k = 0; k < int'(NCELLS); k++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < int'(gap); g++) begin
                drive_cycle(1'b0, 1'b0, 1'b0);
                n_checks++;
                if ({owner, norm_start, cell_cnt} !== {2'd2, 1'b0, 11'(k)}) begin
                    n_fail++;
                    $display("FAIL norm_idle: got owner=%0d norm_start=%b cnt=%0d expected 2 0 %0d", owner, norm_start, cell_cnt, k);
                end
            end
            hd = overrun && (k == 100);
            if (hd) exp_err[0] = 1'b1;
            drive_cycle(hd, 1'b0, 1'b1);
            if (k == int'(NCELLS) - 1) exp_owner = 2'd0;
            n_checks++;
            if ({owner, frame_done, cell_cnt} !== {exp_owner, (k == int'(NCELLS) - 1), 11'(k + 1)}) begin
                n_fail++;
                $display("FAIL norm_count: got owner=%0d frame_done=%b cnt=%0d after pulse %0d", owner, frame_done, cell_cnt, k);
            end
        end
        drive_cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({frame_done, busy, owner, cell_cnt} !== {1'b0, 1'b0, 2'd0, 11'(NCELLS)}) begin
            n_fail++;
            $display("FAIL frame_end: got fd=%b busy=%b owner=%0d cnt=%0d expected 0 0 0 %0d", frame_done, busy, owner, cell_cnt, NCELLS);
        end
    endtask

    task automatic test_reset;
        arest_n = 1'b0;
        histogram_done = 1'b0; sos_valid = 1'b0; norm_cell_valid = 1'b0;
        sos_addra = '1; norm_addra = '1;
        exp_owner = 2'd0; exp_err = 2'b00;
        repeat (3) @(posedge aclk);
        #1;
        n_checks++;
        if ({sos_start, norm_start, normal_addra, owner, busy, frame_done, cell_cnt, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got owner=%0d busy=%b cnt=%0d err=%b addr=%h expected all 0", owner, busy, cell_cnt, err, normal_addra);
        end
        arest_n = 1'b1;
        repeat (6) drive_cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({sos_start, owner, busy, frame_done, cell_cnt} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got sos_start=%b owner=%0d busy=%b cnt=%0d expected all 0", sos_start, owner, busy, cell_cnt);
        end
    endtask

    task automatic test_nominal_frame;
        run_frame(1'b0, 1'b0);
    endtask

    task automatic test_overrun;
        run_frame(1'b1, 1'b0);
    endtask

    task automatic test_stray_valid;
        run_frame(1'b0, 1'b1);
    endtask

    task automatic test_midpass_reset;
        logic [63:0] r;
        drive_cycle(1'b1, 1'b0, 1'b0);
        exp_owner = 2'd1;
        for (int k = 0; k < 500; k++) drive_cycle(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (cell_cnt !== 11'd500) begin
            n_fail++;
            $display("FAIL pre_abort_count: got %0d expected 500", cell_cnt);
        end
        #2;
        r = {$urandom(), $urandom()} | 64'h1;
        sos_addra = r[4*ADDR_W-1:0];
        arest_n = 1'b0;
        #1;
        n_checks++;
        if ({sos_start, norm_start, normal_addra, owner, busy, frame_done, cell_cnt, err} !== '0) begin
            n_fail++;
            $display("FAIL async_abort: got owner=%0d busy=%b cnt=%0d err=%b addr=%h expected all 0", owner, busy, cell_cnt, err, normal_addra);
        end
        exp_owner = 2'd0; exp_err = 2'b00;
        @(posedge aclk);
        #3;
        arest_n = 1'b1;
        @(posedge aclk);
        #1;
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({frame_done, busy, owner} !== 4'b0) begin
            n_fail++;
            $display("FAIL post_abort_idle: got fd=%b busy=%b owner=%0d expected 0 0 0", frame_done, busy, owner);
        end
        run_frame(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_frame(1'b0, 1'b0);
        run_frame(1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_nominal_frame;
        test_overrun;
        test_reset;
        test_stray_valid;
        test_midpass_reset;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
